// File: rtl/multi_gate_occupancy_counter.sv
// ============================================================================
// Module  : multi_gate_occupancy_counter
// Brief   : Per-gate two-beam direction FSMs feeding one saturating occupancy
//           count with full/empty flags, preset load and ovf/unf pulses.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_gate_occupancy_counter #(
  parameter int               GATES    = 2,
  parameter int               CAP      = 200,
  parameter int               CNT_BITS = 8,
  parameter logic [GATES-1:0] GATE_DIR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [GATES-1:0]    sensor_a,
  input  logic [GATES-1:0]    sensor_b,
  input  logic                load,
  input  logic [CNT_BITS-1:0] load_val,
  output logic [CNT_BITS-1:0] count,
  output logic                full,
  output logic                empty,
  output logic [GATES-1:0]    enter_pulse,
  output logic [GATES-1:0]    exit_pulse,
  output logic                ovf,
  output logic                unf
);

  localparam int                     RAW_W = CNT_BITS + $clog2(GATES) + 2;
  localparam logic [CNT_BITS-1:0]    CAP_C = CNT_BITS'(CAP);
  localparam logic signed [RAW_W-1:0] CAP_S = RAW_W'(CAP);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    E1   = 3'd1,
    E2   = 3'd2,
    E3   = 3'd3,
    X1   = 3'd4,
    X2   = 3'd5,
    X3   = 3'd6
  } gate_state_t;

  for (genvar g = 0; g < GATES; g++) begin : g_gate
    gate_state_t state;
    gate_state_t state_nxt;
    logic [1:0]  p;
    logic        ent_nxt;
    logic        ext_nxt;
    logic        ent_q;
    logic        ext_q;

    // Swapped gates see the inner beam as the outer one.
    assign p = GATE_DIR[g] ? {sensor_b[g], sensor_a[g]} : {sensor_a[g], sensor_b[g]};

    always_ff @(posedge clk) begin
      if (reset) begin
        state <= IDLE;
        ent_q <= 1'b0;
        ext_q <= 1'b0;
      end else begin
        state <= state_nxt;
        ent_q <= ent_nxt;
        ext_q <= ext_nxt;
      end
    end

    always_comb begin
      state_nxt = IDLE;
      ent_nxt   = 1'b0;
      ext_nxt   = 1'b0;
      case (state)
        IDLE: state_nxt = (p == 2'b10) ? E1 : (p == 2'b01) ? X1 : IDLE;
        E1:   state_nxt = (p == 2'b10) ? E1 : (p == 2'b11) ? E2 : IDLE;
        X1:   state_nxt = (p == 2'b01) ? X1 : (p == 2'b11) ? X2 : IDLE;
        E2:   state_nxt = (p == 2'b11) ? E2 : (p == 2'b01) ? E3 : (p == 2'b10) ? E1 : IDLE;
        X2:   state_nxt = (p == 2'b11) ? X2 : (p == 2'b10) ? X3 : (p == 2'b01) ? X1 : IDLE;
        E3: begin
          state_nxt = (p == 2'b01) ? E3 : (p == 2'b11) ? E2 : IDLE;
          ent_nxt   = (p == 2'b00);
        end
        X3: begin
          state_nxt = (p == 2'b10) ? X3 : (p == 2'b11) ? X2 : IDLE;
          ext_nxt   = (p == 2'b00);
        end
        default: state_nxt = IDLE;
      endcase
    end

    assign enter_pulse[g] = ent_q;
    assign exit_pulse[g]  = ext_q;
  end

  logic [RAW_W-1:0]        e_sum;
  logic [RAW_W-1:0]        x_sum;
  logic signed [RAW_W-1:0] raw;

  // Entries and exits net out before clamping, so gate ordering never matters.
  always_comb begin
    e_sum = '0;
    x_sum = '0;
    for (int i = 0; i < GATES; i++) begin
      e_sum = e_sum + RAW_W'(enter_pulse[i]);
      x_sum = x_sum + RAW_W'(exit_pulse[i]);
    end
    raw = $signed({{(RAW_W-CNT_BITS){1'b0}}, count}) + $signed(e_sum) - $signed(x_sum);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (load) begin
      count <= (load_val > CAP_C) ? CAP_C : load_val;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (raw > CAP_S) begin
      count <= CAP_C;
      ovf   <= 1'b1;
      unf   <= 1'b0;
    end else if (raw[RAW_W-1]) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b1;
    end else begin
      count <= raw[CNT_BITS-1:0];
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end
  end

  assign full  = (count == CAP_C);
  assign empty = (count == '0);

endmodule

`default_nettype wire

// File: tb/tb_multi_gate_occupancy_counter.sv
// ============================================================================
// Module  : tb_multi_gate_occupancy_counter
// Brief   : Directed self-checking bench; second instance has gate0 swapped.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multi_gate_occupancy_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sa, sb, sa2, sb2;
  logic       load, load2;
  logic [7:0] load_val, load_val2;
  logic [7:0] count, count2;
  logic       full, empty, full2, empty2;
  logic [1:0] enter_pulse, exit_pulse, enter_pulse2, exit_pulse2;
  logic       ovf, unf, ovf2, unf2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_gate_occupancy_counter #(
    .GATES(2), .CAP(200), .CNT_BITS(8), .GATE_DIR(2'b00)
  ) dut (
    .clk(clk), .reset(reset), .sensor_a(sa), .sensor_b(sb),
    .load(load), .load_val(load_val), .count(count), .full(full), .empty(empty),
    .enter_pulse(enter_pulse), .exit_pulse(exit_pulse), .ovf(ovf), .unf(unf)
  );

  multi_gate_occupancy_counter #(
    .GATES(2), .CAP(200), .CNT_BITS(8), .GATE_DIR(2'b01)
  ) dut_sw (
    .clk(clk), .reset(reset), .sensor_a(sa2), .sensor_b(sb2),
    .load(load2), .load_val(load_val2), .count(count2), .full(full2), .empty(empty2),
    .enter_pulse(enter_pulse2), .exit_pulse(exit_pulse2), .ovf(ovf2), .unf(unf2)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive sensor vectors (bit i = gate i) on one instance and hold n cycles.
  task automatic phase(input bit sel, input logic [1:0] a, input logic [1:0] b, input int n);
    if (sel) begin sa2 = a; sb2 = b; end
    else     begin sa  = a; sb  = b; end
    step(n);
  endtask

  task automatic do_load(input bit sel, input logic [7:0] v);
    if (sel) begin load2 = 1'b1; load_val2 = v; end
    else     begin load  = 1'b1; load_val  = v; end
    step(1);
    load = 1'b0;
    load2 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sa = '0; sb = '0; sa2 = '0; sb2 = '0;
    load = 1'b0; load2 = 1'b0; load_val = '0; load_val2 = '0;
    step(3);
    reset = 1'b0;
    step(1);
    check_val("rst_count", count, 0);
    check_val("rst_empty", empty, 1);
    check_val("rst_full", full, 0);
    check_val("rst_pulses", {enter_pulse, exit_pulse}, 0);
    check_val("rst_ovf_unf", {ovf, unf}, 0);

    // Gate0 entry
    phase(0, 2'b00, 2'b00, 3);
    phase(0, 2'b01, 2'b00, 3);
    phase(0, 2'b01, 2'b01, 3);
    phase(0, 2'b00, 2'b01, 3);
    phase(0, 2'b00, 2'b00, 1);
    check_val("t1_enter_pulse", enter_pulse, 1);
    check_val("t1_count_before", count, 0);
    step(1);
    check_val("t1_pulse_gone", enter_pulse, 0);
    check_val("t1_count", count, 1);
    check_val("t1_empty", empty, 0);

    // Gate1 exit from 5
    do_load(0, 8'd5);
    check_val("t2_load", count, 5);
    phase(0, 2'b00, 2'b10, 3);
    phase(0, 2'b10, 2'b10, 3);
    phase(0, 2'b10, 2'b00, 3);
    phase(0, 2'b00, 2'b00, 1);
    check_val("t2_exit_pulse", exit_pulse, 2);
    check_val("t2_no_enter", enter_pulse, 0);
    step(1);
    check_val("t2_count", count, 4);
    check_val("t2_exit_once", exit_pulse, 0);

    // Swapped gate0: exit-ordered beams count as entry
    do_load(1, 8'd5);
    phase(1, 2'b00, 2'b01, 3);
    phase(1, 2'b01, 2'b01, 3);
    phase(1, 2'b01, 2'b00, 3);
    phase(1, 2'b00, 2'b00, 1);
    check_val("t2s_enter_pulse", enter_pulse2, 1);
    check_val("t2s_exit_pulse", exit_pulse2, 0);
    step(1);
    check_val("t2s_count", count2, 6);

    // Back-out and invalid order
    phase(0, 2'b01, 2'b00, 3);
    phase(0, 2'b01, 2'b01, 3);
    phase(0, 2'b01, 2'b00, 3);
    phase(0, 2'b00, 2'b00, 1);
    check_val("t3_backout_pulses", {enter_pulse, exit_pulse}, 0);
    step(1);
    check_val("t3_backout_count", count, 4);
    phase(0, 2'b01, 2'b00, 3);
    phase(0, 2'b00, 2'b01, 3);
    phase(0, 2'b00, 2'b00, 1);
    check_val("t3_invalid_pulses", {enter_pulse, exit_pulse}, 0);
    step(1);
    check_val("t3_invalid_count", count, 4);

    // Overflow: 199 + two simultaneous entries
    do_load(0, 8'd199);
    check_val("t4_load", count, 199);
    phase(0, 2'b11, 2'b00, 3);
    phase(0, 2'b11, 2'b11, 3);
    phase(0, 2'b00, 2'b11, 3);
    phase(0, 2'b00, 2'b00, 1);
    check_val("t4_enter_both", enter_pulse, 3);
    step(1);
    check_val("t4_count_cap", count, 200);
    check_val("t4_full", full, 1);
    check_val("t4_ovf", ovf, 1);
    step(1);
    check_val("t4_ovf_once", ovf, 0);
    phase(0, 2'b00, 2'b10, 3);
    phase(0, 2'b10, 2'b10, 3);
    phase(0, 2'b10, 2'b00, 3);
    phase(0, 2'b00, 2'b00, 2);
    check_val("t4_count_exit", count, 199);
    check_val("t4_not_full", full, 0);

    // Load above CAP clamps
    do_load(0, 8'd250);
    check_val("load_clamp", count, 200);

    // Net-zero at 0, then underflow
    do_load(0, 8'd0);
    phase(0, 2'b01, 2'b10, 3);
    phase(0, 2'b11, 2'b11, 3);
    phase(0, 2'b10, 2'b01, 3);
    phase(0, 2'b00, 2'b00, 1);
    check_val("t5_pulses", {enter_pulse, exit_pulse}, 6);
    step(1);
    check_val("t5_count_net", count, 0);
    check_val("t5_no_unf", {ovf, unf}, 0);
    phase(0, 2'b00, 2'b10, 3);
    phase(0, 2'b10, 2'b10, 3);
    phase(0, 2'b10, 2'b00, 3);
    phase(0, 2'b00, 2'b00, 2);
    check_val("t5_unf", unf, 1);
    check_val("t5_count_zero", count, 0);
    step(1);
    check_val("t5_unf_once", unf, 0);

    // Reset during E2
    do_load(0, 8'd7);
    phase(0, 2'b01, 2'b00, 3);
    phase(0, 2'b01, 2'b01, 3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_val("t6_count_reset", count, 0);
    check_val("t6_pulses_reset", {enter_pulse, exit_pulse}, 0);
    step(2);
    phase(0, 2'b00, 2'b01, 3);
    phase(0, 2'b00, 2'b00, 1);
    check_val("t6_no_pulse", {enter_pulse, exit_pulse}, 0);
    step(1);
    check_val("t6_count", count, 0);
    check_val("t6_empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
